// File: rtl/simple_cpu_rom_loader.sv
// UART program loader and boot-ROM responder for simple_cpu.
// Define ROM_LOADER_CHECKSUM_EN to require a trailing checksum byte on each image.
module simple_cpu_rom_loader #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             uart_rxd,
    input  logic [DEPTH-1:0] rom_addr,
    output logic [31:0]      rom_data,
    output logic             cpu_reset,
    output logic             load_done,
    output logic             load_err
);
    localparam int DIV   = CLK_HZ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);
    localparam int WORDS = 1 << DEPTH;
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [7:0]       HDR      = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [2:0] {
        L_CLEAR,
        L_HUNT,
        L_COUNT,
        L_DATA,
`ifdef ROM_LOADER_CHECKSUM_EN
        L_CSUM,
`endif
        L_RUN
    } ld_state_t;

    rx_state_t        rx_state_q, rx_state_d;
    logic             rxd_s1_q, rxd_s2_q, rxd_prev_q;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_ferr_q, rx_ferr_d;

    ld_state_t        ld_state_q, ld_state_d;
    logic [DEPTH-1:0] waddr_q, waddr_d;
    logic [8:0]       words_q, words_d;
    logic [1:0]       bidx_q, bidx_d;
    logic [23:0]      asm_q, asm_d;
    logic [7:0]       csum_q, csum_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             load_done_q, load_done_d;
    logic             load_err_q, load_err_d;
    logic             hdr_seen;

    logic             we;
    logic [31:0]      wd;
    logic [31:0]      mem [WORDS];
    logic [31:0]      rom_data_q;

    // ---- RX front end: synchronizer, start validation, bit sampling
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rxd_s1_q   <= uart_rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    always_ff @(posedge clk) begin
        rx_shift_q <= rx_shift_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rxd_prev_q && !rxd_s2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                // Line must still be low mid-start-bit, otherwise it was a glitch.
                if (rx_cnt_q == CNT_MID) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_state_d = RX_IDLE;
                    rx_valid_d = rxd_s2_q;
                    rx_ferr_d  = !rxd_s2_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---- Loader FSM: clear RAM, parse frame, gate CPU reset
    assign hdr_seen = rx_valid_q && (rx_shift_q == HDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_state_q  <= L_CLEAR;
            waddr_q     <= '0;
            words_q     <= '0;
            bidx_q      <= '0;
            cpu_reset_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            ld_state_q  <= ld_state_d;
            waddr_q     <= waddr_d;
            words_q     <= words_d;
            bidx_q      <= bidx_d;
            cpu_reset_q <= cpu_reset_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    always_ff @(posedge clk) begin
        asm_q  <= asm_d;
        csum_q <= csum_d;
    end

    always_comb begin
        ld_state_d  = ld_state_q;
        waddr_d     = waddr_q;
        words_d     = words_q;
        bidx_d      = bidx_q;
        asm_d       = asm_q;
        csum_d      = csum_q;
        cpu_reset_d = cpu_reset_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q | rx_ferr_q;
        we          = 1'b0;
        wd          = {rx_shift_q, asm_q};
        case (ld_state_q)
            L_CLEAR: begin
                we      = 1'b1;
                wd      = '0;
                waddr_d = waddr_q + 1'b1;
                if (waddr_q == '1) ld_state_d = L_HUNT;
            end
            L_HUNT, L_RUN: begin
                if (hdr_seen) begin
                    cpu_reset_d = 1'b1;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                    waddr_d     = '0;
                    csum_d      = '0;
                    bidx_d      = '0;
                    ld_state_d  = L_COUNT;
                end
            end
            L_COUNT: begin
                if (rx_valid_q) begin
                    words_d    = (rx_shift_q == 8'h00) ? 9'd256 : {1'b0, rx_shift_q};
                    ld_state_d = L_DATA;
                end
            end
            L_DATA: begin
                if (rx_valid_q) begin
                    csum_d = csum_q + rx_shift_q;
                    bidx_d = bidx_q + 2'd1;
                    asm_d  = {rx_shift_q, asm_q[23:8]};
                    if (bidx_q == 2'd3) begin
                        we      = 1'b1;
                        waddr_d = waddr_q + 1'b1;
                        words_d = words_q - 9'd1;
                        if (words_q == 9'd1) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                            ld_state_d  = L_CSUM;
`else
                            ld_state_d  = L_RUN;
                            cpu_reset_d = 1'b0;
                            load_done_d = 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            L_CSUM: begin
                if (rx_valid_q) begin
                    if (rx_shift_q == csum_q) begin
                        ld_state_d  = L_RUN;
                        cpu_reset_d = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        ld_state_d = L_HUNT;
                        load_err_d = 1'b1;
                    end
                end
            end
`endif
            default: ld_state_d = L_HUNT;
        endcase
    end

    // ---- Image RAM: write-first on address collision
    always_ff @(posedge clk) begin
        if (we) mem[waddr_q] <= wd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        rom_data_q <= '0;
        else if (we && waddr_q == rom_addr) rom_data_q <= wd;
        else                              rom_data_q <= mem[rom_addr];
    end

    assign rom_data  = rom_data_q;
    assign cpu_reset = cpu_reset_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_simple_cpu_rom_loader.sv
// Directed + randomized bench for simple_cpu_rom_loader with a frame-level reference model.
module tb_simple_cpu_rom_loader;
    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int DIV    = 10;
    localparam int DEPTH  = 8;
`ifdef ROM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             uart_rxd = 1'b1;
    logic [DEPTH-1:0] rom_addr = '0;
    logic [31:0]      rom_data;
    logic             cpu_reset, load_done, load_err;

    simple_cpu_rom_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .rom_addr(rom_addr),
        .rom_data(rom_data), .cpu_reset(cpu_reset), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem_m [256];
    logic rst_m, done_m, err_m;
    int rst_chg, done_chg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output change must land one cycle after rx_valid, i.e. ~98 cycles after the start edge.
    task automatic check_win(input string tag, input int got);
        checks++;
        assert (got >= 96 && got <= 100) else begin
            errors++;
            $error("FAIL %s: change at cycle %0d, expected 96..100", tag, got);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, " cpu_reset"}, cpu_reset, rst_m);
        check({tag, " load_done"}, load_done, done_m);
        check({tag, " load_err"},  load_err,  err_m);
    endtask

    task automatic read_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        rom_addr = a;
        @(posedge clk); #1;
        check(tag, rom_data, exp);
    endtask

    // Drives one 8N1 byte (plus 4 idle cycles) and records when cpu_reset/load_done first change.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        logic [9:0] bits;
        logic r0, d0;
        int n;
        bits = {stop_bit, b, 1'b0};
        r0 = cpu_reset; d0 = load_done;
        rst_chg = -1; done_chg = -1; n = 0;
        for (int i = 0; i < 11; i++) begin
            uart_rxd = (i < 10) ? bits[i] : 1'b1;
            for (int c = 0; c < ((i < 10) ? DIV : 4); c++) begin
                @(posedge clk); #1;
                n++;
                if (rst_chg < 0 && cpu_reset !== r0) rst_chg = n;
                if (done_chg < 0 && load_done !== d0) done_chg = n;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] fr[$]);
        foreach (fr[i]) send_byte(fr[i]);
    endtask

    task automatic make_frame(input logic [31:0] w[$], input bit corrupt, output logic [7:0] fr[$]);
        logic [7:0] sum;
        sum = 8'h00;
        fr = {};
        fr.push_back(8'hA5);
        fr.push_back(8'(w.size()));
        foreach (w[i]) begin
            for (int b = 0; b < 4; b++) begin
                fr.push_back(w[i][8*b +: 8]);
                sum = sum + w[i][8*b +: 8];
            end
        end
        if (CSUM_EN) fr.push_back(corrupt ? (sum ^ 8'h5C) : sum);
    endtask

    // Whole-frame effect: words land from address 0; image accepted iff checksum (if any) matches.
    task automatic model_frame(input logic [7:0] fr[$]);
        int n;
        logic [7:0] sum;
        bit ok;
        n = (fr[1] == 8'h00) ? 256 : int'(fr[1]);
        sum = 8'h00;
        for (int k = 0; k < n; k++) begin
            mem_m[k] = {fr[2+4*k+3], fr[2+4*k+2], fr[2+4*k+1], fr[2+4*k]};
            for (int b = 0; b < 4; b++) sum = sum + fr[2+4*k+b];
        end
        if (CSUM_EN) ok = (fr[2+4*n] == sum);
        else         ok = 1'b1;
        rst_m = !ok; done_m = ok; err_m = !ok;
    endtask

    initial begin
        logic [7:0]  fr[$];
        logic [7:0]  tail[$];
        logic [31:0] w[$];
        int n;
        bit corrupt;

        for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
        rst_m = 1'b1; done_m = 1'b0; err_m = 1'b0;

        repeat (3) @(posedge clk); #1;
        check("reset rom_data", rom_data, 32'h0);
        check_state("reset");
        reset = 1'b0;
        repeat (260) @(posedge clk); #1;
        check("clear cpu_reset", cpu_reset, 1'b1);
        read_chk("clear ram[0]", 8'd0, 32'h0);
        read_chk("clear ram[1]", 8'd1, 32'h0);
        read_chk("clear ram[255]", 8'd255, 32'h0);
        check_state("clear");

        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        check_state("noise");

        fr = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, 8'h48, 8'h05, 8'h00, 8'h00, 8'h00};
`ifdef ROM_LOADER_CHECKSUM_EN
        fr.push_back(8'h4F);
        send_frame(fr);
        check("badsum load_err", load_err, 1'b1);
        check("badsum cpu_reset", cpu_reset, 1'b1);
        check("badsum load_done", load_done, 1'b0);
        fr[10] = 8'h4E;
`endif
        send_frame(fr);
        model_frame(fr);
        check_win("good release", rst_chg);
        check_win("good done", done_chg);
        check_state("good");
        read_chk("good ram[0]", 8'd0, 32'h48000001);
        read_chk("good ram[1]", 8'd1, 32'h00000005);

`ifndef ROM_LOADER_CHECKSUM_EN
        fr = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h00, 8'h48};
        send_frame(fr);
        model_frame(fr);
        check_win("nocsum release", rst_chg);
        check_state("nocsum");
        read_chk("nocsum ram[0]", 8'd0, 32'h48000001);
`endif

        send_byte(8'h00, 1'b0);
        err_m = 1'b1;
        check_state("framing error");

        uart_rxd = 1'b0;
        repeat (2) @(posedge clk); #1;
        uart_rxd = 1'b1;
        repeat (15) @(posedge clk); #1;
        send_byte(8'hA5);
        rst_m = 1'b1; done_m = 1'b0; err_m = 1'b0;
        check_win("reload cpu_reset rise", rst_chg);
        check_win("reload load_done fall", done_chg);
        check_state("reload header");
        w = '{32'h00000040};
        make_frame(w, 1'b0, fr);
        tail = fr[1:$];
        send_frame(tail);
        model_frame(fr);
        check_state("reload");
        read_chk("reload ram[0]", 8'd0, 32'h00000040);
        read_chk("reload ram[1]", 8'd1, 32'h00000005);

        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 5);
            w = {};
            for (int i = 0; i < n; i++) w.push_back($urandom);
            corrupt = CSUM_EN && ($urandom_range(0, 3) == 0);
            make_frame(w, corrupt, fr);
            send_frame(fr);
            model_frame(fr);
            check_state($sformatf("rand%0d", k));
            if (!rst_m) check_win($sformatf("rand%0d release", k), rst_chg);
            for (int a = 0; a <= n; a++) read_chk($sformatf("rand%0d ram[%0d]", k, a), 8'(a), mem_m[a]);
        end

        rom_addr = 8'd0;
        send_byte(8'hA5);
        send_byte(8'h03);
        uart_rxd = 1'b0;
        repeat (30) @(posedge clk); #1;
        reset = 1'b1;
        #2;
        for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
        rst_m = 1'b1; done_m = 1'b0; err_m = 1'b0;
        check("async reset rom_data", rom_data, 32'h0);
        check_state("async reset");
        uart_rxd = 1'b1;
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        repeat (260) @(posedge clk); #1;
        read_chk("post-reset ram[0]", 8'd0, 32'h0);
        read_chk("post-reset ram[2]", 8'd2, 32'h0);
        check_state("post-reset");

        w = '{32'hDEADBEEF};
        make_frame(w, 1'b0, fr);
        send_frame(fr);
        model_frame(fr);
        check_state("recover");
        read_chk("recover ram[0]", 8'd0, mem_m[0]);
        read_chk("recover ram[1]", 8'd1, mem_m[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/simple_cpu_rom_loader.md
# simple_cpu_rom_loader

Serial program loader and instruction-ROM responder for `simple_cpu`. It receives a framed program image over a UART line and stores it in an internal 256x32 RAM. It holds the CPU in reset until a complete, valid image has been stored. It then answers the CPU's boot-time `rom_addr`/`rom_data` reads from that RAM, replacing a fixed synthesized ROM so programs can be reloaded without rebuilding the bitstream.

## Interface
Parameters:
- `CLK_HZ`, 50000000: clock frequency in Hz.
- `BAUD`, 115200: UART bit rate. `DIV = CLK_HZ/BAUD`, integer division; `DIV` must be at least 4.
- `DEPTH`, 8: address width of the image RAM, giving 2^DEPTH words.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `uart_rxd`, input, 1: serial data, idle high, 8N1, LSB first. It is asynchronous to `clk`.
- `rom_addr`, input, DEPTH: read address driven by the CPU.
- `rom_data`, output, 32: read data, registered.
- `cpu_reset`, output, 1: active-high reset to `simple_cpu`.
- `load_done`, output, 1: high while a verified image is resident.
- `load_err`, output, 1: sticky error flag, cleared by the next accepted header.

## Operation
- RX front end:
  - Two-flop synchronizer on `uart_rxd`.
  - A falling edge in idle starts a frame. The line is resampled at `DIV/2`; if it is high there, the start is a glitch and the receiver returns to idle.
  - The 8 data bits are then sampled every `DIV` cycles, followed by the stop bit.
  - If the stop bit is 0, the byte is discarded and `load_err` is set.
  - A good byte produces a one-cycle `rx_valid` pulse with `rx_byte`.
- Loader FSM states: CLEAR, HUNT, COUNT, DATA, CSUM, RUN.
  - CLEAR (entered on reset): writes 0 to addresses 0..2^DEPTH-1, one per cycle, then goes to HUNT. Bytes arriving during CLEAR are dropped.
  - HUNT: waits for byte 0xA5; all other bytes are ignored. On 0xA5:
    - assert `cpu_reset`;
    - clear `load_done`, `load_err`, the write address and the checksum;
    - go to COUNT.
  - COUNT: the next byte is N, the word count; N=0 means 256 words. Go to DATA.
  - DATA: bytes are assembled little-endian into a 32-bit word; the first byte is bits [7:0].
    - On the 4th byte, write the word at the write address, then increment the address.
    - After word N, go to CSUM. Without the checksum feature, go to RUN instead.
  - CSUM: compare the byte with the 8-bit modulo sum of all DATA bytes.
    - Match: go to RUN.
    - Mismatch: set `load_err`, stay in reset, go to HUNT.
  - RUN: deassert `cpu_reset` and set `load_done`. A 0xA5 byte re-enters the HUNT acceptance action and reloads the image. All other bytes are ignored.
- Addresses not written by an image keep their previous contents (0 after CLEAR, which the CPU decodes as HALT).
- The write port has priority over the read port in the same cycle. A read only collides with a write while `cpu_reset` is high, so this is harmless.

## Timing
- Reset values:
  - `rom_data` = 0
  - `cpu_reset` = 1
  - `load_done` = 0
  - `load_err` = 0
  - FSM in CLEAR at address 0.
- Read latency:
  - `rom_data` = RAM[`rom_addr`], registered 1 cycle after `rom_addr` is sampled. The CPU samples it 2 cycles after driving the address.
  - Reads are always serviced, in any state.
- Write timing: the RAM write occurs in the cycle after the `rx_valid` of a word's 4th byte.
- Release: `cpu_reset` falls and `load_done` rises in the same cycle, 1 cycle after the final accepted byte's `rx_valid`.
- Byte-to-`rx_valid` latency: `rx_valid` pulses 2 sync cycles + `DIV/2` + 9·`DIV` cycles after the start edge, ±1 cycle.
- Mid-frame `reset`: everything returns to its reset values asynchronously. The partial image is discarded by CLEAR.
- A header byte 0xA5 inside DATA is treated as data, not as a new header.

## Configuration
- `ROM_LOADER_CHECKSUM_EN` defined: the frame is 0xA5, N, 4N data bytes, checksum byte. The CSUM state is present and a mismatch sets `load_err`.
- `ROM_LOADER_CHECKSUM_EN` undefined:
  - the frame has no checksum byte and the CSUM state is not built;
  - the image commits to RUN directly after word N;
  - `load_err` is set only by framing errors.

## Test plan
Use `CLK_HZ`=1000000, `BAUD`=100000 (`DIV`=10) and `ROM_LOADER_CHECKSUM_EN` defined, unless noted.

- **Reset and CLEAR:** after reset, read addresses 0, 1 and 255 once `cpu_reset` is still 1 after 256 cycles -> `rom_data`=0 each, `load_done`=0.
- **Good load:** send A5 02 01 00 00 48 05 00 00 00 4E -> RAM[0]=0x48000001, RAM[1]=0x00000005. `cpu_reset` falls one cycle after the 4E byte, `load_done`=1, `load_err`=0.
- **Bad checksum:** same frame ending in 4F -> `load_err`=1, `cpu_reset` stays 1, FSM in HUNT. A following good frame clears `load_err` and releases reset.
- **Noise and framing errors:**
  - bytes 00 FF 5A before A5 -> ignored.
  - a byte with stop bit 0 -> discarded and `load_err`=1.
  - a 2-cycle low glitch on `uart_rxd` -> no `rx_valid`.
- **Reload from RUN:** in RUN, send A5 -> `cpu_reset`=1 and `load_done`=0 in the cycle after `rx_valid`. Load N=1 with word 0x00000040 -> RAM[0]=0x40, released. RAM[1] keeps its earlier value.
- **Macro off:** frame A5 01 01 00 00 48 -> released one cycle after the 4th data byte, with no checksum byte expected.
